// File: rtl/ddcb_pkg.sv
// Shared types and helpers for the DDCB delay-line calibrator.
// Holds the FSM state encoding, the default cascade count and the code-to-thermometer mapping.
package ddcb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } cal_state_t;

  localparam int DDCB_NMBR_CASCADES = 4;
  localparam int DDCB_MAX_CASCADES  = 32;

  // Bit i is set when stage i is enabled, i.e. i < code; callers truncate to their width.
  function automatic logic [DDCB_MAX_CASCADES-1:0] code2therm(input int unsigned code);
    logic [DDCB_MAX_CASCADES-1:0] therm;
    therm = '0;
    for (int unsigned i = 0; i < DDCB_MAX_CASCADES; i++) begin
      therm[i] = (i < code);
    end
    return therm;
  endfunction

endpackage

// File: rtl/ddcb_delay_calibrator_vote_acc.sv
// Phase-detector vote accumulator: counts valid samples and late samples for one code setting.
// vote_done_o flags the cycle in which the final sample of the vote is being accepted.
module ddcb_vote_acc #(
  parameter int VOTE_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  input  logic pd_valid_i,
  input  logic pd_late_i,
  output logic vote_done_o,
  output logic vote_late_o
);

  localparam int CW = $clog2(VOTE_SAMPLES + 1);

  logic [CW-1:0] sample_q, sample_d;
  logic [CW-1:0] late_q, late_d;
  logic          take;

  assign take = en_i & pd_valid_i;

  always_comb begin
    sample_d = sample_q;
    late_d   = late_q;
    if (clear_i) begin
      sample_d = '0;
      late_d   = '0;
    end else if (take) begin
      sample_d = sample_q + CW'(1);
      late_d   = late_q + CW'(pd_late_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      late_q   <= '0;
    end else begin
      sample_q <= sample_d;
      late_q   <= late_d;
    end
  end

  // The vote is judged once all samples are in, so late_q is final by the time it is read.
  assign vote_done_o = take & (sample_q == CW'(VOTE_SAMPLES - 1));
  assign vote_late_o = (late_q > CW'(VOTE_SAMPLES / 2));

endmodule

// File: rtl/ddcb_delay_calibrator.sv
// Delay-line calibration controller: sweeps the enabled stage count upward from zero and
// locks on the first setting whose majority phase-detector vote says the delayed edge is late.
module ddcb_delay_calibrator
  import ddcb_pkg::*;
#(
  parameter int NMBR_CASCADES = DDCB_NMBR_CASCADES,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTE_SAMPLES  = 8,
  parameter int CODE_W        = $clog2(NMBR_CASCADES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cal_start_i,
  input  logic                     manual_en_i,
  input  logic [CODE_W-1:0]        manual_code_i,
  input  logic                     pd_valid_i,
  input  logic                     pd_late_i,
  output logic [NMBR_CASCADES-1:0] select_o,
  output logic [CODE_W-1:0]        code_out_o,
  output logic                     cal_busy_o,
  output logic                     cal_done_o,
  output logic                     cal_lock_o,
  output logic                     cal_err_o,
  output cal_state_t               dbg_state_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(NMBR_CASCADES);

  cal_state_t               state_q, state_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [NMBR_CASCADES-1:0] select_q, select_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     lock_q, lock_d;
  logic                     err_q, err_d;
  logic                     vote_clr;
  logic                     vote_en;
  logic                     vote_done;
  logic                     vote_late;
  logic [CODE_W-1:0]        manual_clamped;

  assign manual_clamped = (manual_code_i > CODE_MAX) ? CODE_MAX : manual_code_i;

  ddcb_vote_acc #(
    .VOTE_SAMPLES(VOTE_SAMPLES)
  ) u_vote_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (vote_clr),
    .en_i       (vote_en),
    .pd_valid_i (pd_valid_i),
    .pd_late_i  (pd_late_i),
    .vote_done_o(vote_done),
    .vote_late_o(vote_late)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    lock_d   = lock_q;
    err_d    = err_q;
    vote_clr = 1'b0;
    vote_en  = 1'b0;

    if (manual_en_i) begin
      // Manual override wins from any state and wipes the previous calibration result.
      state_d = IDLE;
      code_d  = manual_clamped;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      lock_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cal_start_i) begin
            state_d  = SETTLE;
            code_d   = '0;
            settle_d = SW'(SETTLE_CYCLES);
            vote_clr = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            lock_d   = 1'b0;
            err_d    = 1'b0;
          end
        end
        SETTLE: begin
          settle_d = settle_q - SW'(1);
          if (settle_q == SW'(1)) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          vote_en = 1'b1;
          if (vote_done) begin
            state_d = DECIDE;
          end
        end
        DECIDE: begin
          vote_clr = 1'b1;
          if (vote_late) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            lock_d  = 1'b1;
          end else if (code_q < CODE_MAX) begin
            state_d  = SETTLE;
            code_d   = code_q + CODE_W'(1);
            settle_d = SW'(SETTLE_CYCLES);
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    // select is registered from the same next code so it moves on the same edge as code_out.
    select_d = NMBR_CASCADES'(code2therm(32'(code_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      settle_q <= '0;
      select_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      settle_q <= settle_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  assign select_o    = select_q;
  assign code_out_o  = code_q;
  assign cal_busy_o  = busy_q;
  assign cal_done_o  = done_q;
  assign cal_lock_o  = lock_q;
  assign cal_err_o   = err_q;
  assign dbg_state_o = state_q;

endmodule
